ahb_lite_arbiter2: RTL and testbench

AHB_LITE_ARBITER2 -- requirements
Module: ahb_lite_arbiter2

---
 rtl/ahb_lite_arbiter2_pkg.sv | 19 +
 rtl/ahb_lite_arbiter2_if.sv | 24 ++
 rtl/ahb_lite_arb_rr.sv | 71 +++++++
 rtl/ahb_lite_arbiter2.sv | 66 ++++++
 tb/tb_ahb_lite_arbiter2.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_lite_arbiter2_pkg.sv
// AHB-Lite encodings and arbiter state type shared by the two-master arbiter,
// its round-robin core and the bench.
package ahb_lite_defs;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;

   localparam logic [2:0] HSIZE_X32     = 3'b010;

   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ahb_lite_arbiter2_if.sv
// One AHB-Lite link. The master modport drives address/control/write data;
// the slave modport answers with read data, ready and response.
interface ahb_lite_arbiter2_if;
   logic        hsel;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output hsel, htrans, haddr, hburst, hsize, hwrite, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, htrans, haddr, hburst, hsize, hwrite, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/ahb_lite_arb_rr.sv
// Round-robin owner tracking for two AHB-Lite masters, with WRAP4 burst lock.
//
// state      | meaning
// ARB_OPEN   | no burst in flight; ownership may move on an accepting edge
// ARB_LOCKED | WRAP4 in flight; beat_cnt = SEQ beats still to be accepted
module ahb_lite_arb_rr
   import ahb_lite_defs::*;
(
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       hreadyout,
   input  logic [1:0] req,
   input  logic [1:0] own_htrans,
   input  logic [2:0] own_hburst,
   output logic       addr_owner,
   output logic       data_owner,
   output logic       data_valid,
   output logic       locked
);

   arb_state_t state, nxt_state;
   logic [1:0] beat_cnt, nxt_cnt;
   logic       own_req;
   logic       handover;

   assign own_req = req[addr_owner];
   assign locked  = (state == ARB_LOCKED);

   // Dropping the request mid-burst abandons it, so the lock never outlives the owner.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = beat_cnt;
      if (!own_req) begin
         nxt_state = ARB_OPEN;
         nxt_cnt   = 2'd0;
      end else if (own_htrans == HTRANS_NONSEQ) begin
         if (own_hburst == HBURST_WRAP4) begin
            nxt_state = ARB_LOCKED;
            nxt_cnt   = 2'd3;
         end else begin
            nxt_state = ARB_OPEN;
            nxt_cnt   = 2'd0;
         end
      end else if (state == ARB_LOCKED) begin
         nxt_cnt = beat_cnt - 2'd1;
         if (beat_cnt == 2'd1) begin
            nxt_state = ARB_OPEN;
         end
      end
      handover = (nxt_state == ARB_OPEN) && req[~addr_owner];
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state      <= ARB_OPEN;
         beat_cnt   <= 2'd0;
         addr_owner <= 1'b0;
         data_owner <= 1'b0;
         data_valid <= 1'b0;
      end else if (hreadyout) begin
         state      <= nxt_state;
         beat_cnt   <= nxt_cnt;
         data_owner <= addr_owner;
         data_valid <= own_req;
         if (handover) begin
            addr_owner <= ~addr_owner;
         end
      end
   end

endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter in front of one shared slave (SDRAM controller).
// Address phase follows GRANT; write data and responses follow the data-phase owner.
module ahb_lite_arbiter2
   import ahb_lite_defs::*;
(
   input  logic                HCLK,
   input  logic                HRESET,
   ahb_lite_arbiter2_if.slave  m0,
   ahb_lite_arbiter2_if.slave  m1,
   ahb_lite_arbiter2_if.master s,
   output logic                GRANT,
   output logic                LOCKED
);

   logic [1:0]  req;
   logic        addr_owner;
   logic        data_owner;
   logic        data_valid;
   logic        own_hsel;
   logic [1:0]  own_htrans;
   logic [2:0]  own_hburst;
   logic        m0_data;
   logic        m1_data;

   assign req = {m1.hsel & m1.htrans[1], m0.hsel & m0.htrans[1]};

   assign own_hsel   = addr_owner ? m1.hsel : m0.hsel;
   assign own_htrans = !own_hsel ? HTRANS_IDLE : (addr_owner ? m1.htrans : m0.htrans);
   assign own_hburst = addr_owner ? m1.hburst : m0.hburst;

   ahb_lite_arb_rr u_rr (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .hreadyout  (s.hready),
      .req        (req),
      .own_htrans (own_htrans),
      .own_hburst (own_hburst),
      .addr_owner (addr_owner),
      .data_owner (data_owner),
      .data_valid (data_valid),
      .locked     (LOCKED)
   );

   assign GRANT = addr_owner;

   assign s.hsel   = own_hsel;
   assign s.htrans = own_htrans;
   assign s.haddr  = addr_owner ? m1.haddr  : m0.haddr;
   assign s.hburst = own_hburst;
   assign s.hsize  = addr_owner ? m1.hsize  : m0.hsize;
   assign s.hwrite = addr_owner ? m1.hwrite : m0.hwrite;
   assign s.hwdata = data_owner ? m1.hwdata : m0.hwdata;

   assign m0_data = data_valid && !data_owner;
   assign m1_data = data_valid &&  data_owner;

   // A waiting master sees HREADY low, which holds its address phase on the bus.
   assign m0.hready = (!addr_owner || m0_data) ? s.hready : 1'b0;
   assign m1.hready = ( addr_owner || m1_data) ? s.hready : 1'b0;

   assign m0.hrdata = m0_data ? s.hrdata : 32'h0;
   assign m1.hrdata = m1_data ? s.hrdata : 32'h0;
   assign m0.hresp  = m0_data ? s.hresp  : 1'b0;
   assign m1.hresp  = m1_data ? s.hresp  : 1'b0;

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Bench for the two-master AHB-Lite arbiter: directed vector table, burst
// corner sequences and a randomized run against a transaction-level model.
module tb_ahb_lite_arbiter2;
   import ahb_lite_defs::*;

   logic HCLK = 1'b0;
   logic HRESET;
   logic GRANT, LOCKED;

   always #5 HCLK = ~HCLK;

   ahb_lite_arbiter2_if m0_if ();
   ahb_lite_arbiter2_if m1_if ();
   ahb_lite_arbiter2_if s_if ();

   ahb_lite_arbiter2 dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .m0     (m0_if),
      .m1     (m1_if),
      .s      (s_if),
      .GRANT  (GRANT),
      .LOCKED (LOCKED)
   );

   logic        b_sel   [2];
   logic [1:0]  b_tr    [2];
   logic [31:0] b_addr  [2];
   logic [2:0]  b_burst [2];
   logic [2:0]  b_size  [2];
   logic        b_wr    [2];
   logic [31:0] b_wd    [2];
   logic        b_srdy;
   logic [31:0] b_srd;
   logic        b_sresp;

   assign m0_if.hsel   = b_sel[0];   assign m1_if.hsel   = b_sel[1];
   assign m0_if.htrans = b_tr[0];    assign m1_if.htrans = b_tr[1];
   assign m0_if.haddr  = b_addr[0];  assign m1_if.haddr  = b_addr[1];
   assign m0_if.hburst = b_burst[0]; assign m1_if.hburst = b_burst[1];
   assign m0_if.hsize  = b_size[0];  assign m1_if.hsize  = b_size[1];
   assign m0_if.hwrite = b_wr[0];    assign m1_if.hwrite = b_wr[1];
   assign m0_if.hwdata = b_wd[0];    assign m1_if.hwdata = b_wd[1];
   assign s_if.hready  = b_srdy;
   assign s_if.hrdata  = b_srd;
   assign s_if.hresp   = b_sresp;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Transaction-level model: who owns the address bus, who owns the data
   // phase, and how many burst beats the current owner still has to deliver.
   int mdl_owner, mdl_downer, mdl_left;
   bit mdl_dvalid, mdl_ok;

   task automatic model_update();
      bit want [2];
      int o;
      if (HRESET) begin
         mdl_owner = 0; mdl_downer = 0; mdl_dvalid = 0; mdl_left = 0; mdl_ok = 1;
      end else if (b_srdy && mdl_ok) begin
         for (int n = 0; n < 2; n++) want[n] = b_sel[n] && (b_tr[n] == HTRANS_NONSEQ || b_tr[n] == HTRANS_SEQ);
         o = mdl_owner;
         mdl_downer = o;
         mdl_dvalid = want[o];
         if (!want[o])                      mdl_left = 0;
         else if (b_tr[o] == HTRANS_NONSEQ) mdl_left = (b_burst[o] == HBURST_WRAP4) ? 3 : 0;
         else if (mdl_left > 0)             mdl_left = mdl_left - 1;
         if (mdl_left == 0 && want[1 - o]) mdl_owner = 1 - o;
      end
   endtask

   task automatic model_check();
      int o, d;
      logic act_rdy, act_resp;
      logic [31:0] act_rd;
      bit in_data;
      if (!mdl_ok) return;
      o = mdl_owner; d = mdl_downer;
      chk("m_grant",  {31'b0, GRANT}, o);
      chk("m_locked", {31'b0, LOCKED}, {31'b0, mdl_left > 0});
      chk("m_hsel",   {31'b0, s_if.hsel}, {31'b0, b_sel[o]});
      chk("m_htrans", {30'b0, s_if.htrans}, {30'b0, b_sel[o] ? b_tr[o] : HTRANS_IDLE});
      chk("m_haddr",  s_if.haddr, b_addr[o]);
      chk("m_hctl",   {25'b0, s_if.hburst, s_if.hsize, s_if.hwrite}, {25'b0, b_burst[o], b_size[o], b_wr[o]});
      chk("m_hwdata", s_if.hwdata, b_wd[d]);
      for (int n = 0; n < 2; n++) begin
         in_data  = mdl_dvalid && (n == d);
         act_rdy  = (n == 0) ? m0_if.hready : m1_if.hready;
         act_rd   = (n == 0) ? m0_if.hrdata : m1_if.hrdata;
         act_resp = (n == 0) ? m0_if.hresp  : m1_if.hresp;
         chk("m_hready", {31'b0, act_rdy}, {31'b0, (n == o || in_data) ? b_srdy : 1'b0});
         chk("m_hrdata", act_rd, in_data ? b_srd : 32'h0);
         chk("m_hresp",  {31'b0, act_resp}, {31'b0, in_data ? b_sresp : 1'b0});
      end
   endtask

   task automatic settle();
      @(negedge HCLK);
      model_check();
   endtask

   task automatic advance();
      @(posedge HCLK);
      model_update();
      #1;
   endtask

   task automatic setm(input int n, input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                       input logic [2:0] burst, input logic wr, input logic [31:0] wd);
      b_sel[n] = sel; b_tr[n] = tr; b_addr[n] = addr; b_burst[n] = burst;
      b_size[n] = HSIZE_X32; b_wr[n] = wr; b_wd[n] = wd;
   endtask

   typedef struct {
      logic rst; logic s_rdy; logic [31:0] s_rd;
      logic sel0; logic [1:0] tr0; logic [31:0] addr0; logic wr0; logic [31:0] wd0;
      logic sel1; logic [1:0] tr1; logic [31:0] addr1; logic [31:0] wd1;
      logic e_grant; logic [1:0] e_htrans; logic [31:0] e_haddr; logic [31:0] e_hwdata;
      logic e_rdy0; logic e_rdy1; logic [31:0] e_rd0;
   } vec_t;

   localparam logic [1:0] ID = HTRANS_IDLE;
   localparam logic [1:0] NS = HTRANS_NONSEQ;
   localparam logic [1:0] SQ = HTRANS_SEQ;

   vec_t vec [18];

   initial begin
      int r;
      mdl_ok = 0; mdl_owner = 0; mdl_downer = 0; mdl_left = 0; mdl_dvalid = 0;
      HRESET = 1'b1; b_srdy = 1'b1; b_srd = 32'h0; b_sresp = 1'b0;
      setm(0, 0, ID, 32'h0, HBURST_SINGLE, 0, 32'h0);
      setm(1, 0, ID, 32'h0, HBURST_SINGLE, 1, 32'h0);

      // rst s_rdy s_rd | m0 sel tr addr wr wd | m1 sel tr addr wd | grant htrans haddr hwdata rdy0 rdy1 rd0
      vec[0]  = '{1,1,32'h0,        0,ID,32'h10,0,32'h0,        0,ID,32'h0,32'h0,     0,ID,32'h10,32'h0,        1,0,32'h0};
      vec[1]  = '{1,0,32'h0,        0,ID,32'h10,0,32'h0,        0,ID,32'h0,32'h0,     0,ID,32'h10,32'h0,        0,0,32'h0};
      vec[2]  = '{0,1,32'h0,        1,NS,32'h10,1,32'h0,        0,ID,32'h0,32'h0,     0,NS,32'h10,32'h0,        1,0,32'h0};
      vec[3]  = '{0,1,32'h0,        0,ID,32'h10,1,32'hA5A5A5A5, 0,ID,32'h0,32'h0,     0,ID,32'h10,32'hA5A5A5A5, 1,0,32'h0};
      vec[4]  = '{0,1,32'h0,        1,NS,32'h10,0,32'h0,        0,ID,32'h0,32'h0,     0,NS,32'h10,32'h0,        1,0,32'h0};
      vec[5]  = '{0,1,32'hA5A5A5A5, 0,ID,32'h10,0,32'h0,        0,ID,32'h0,32'h0,     0,ID,32'h10,32'h0,        1,0,32'hA5A5A5A5};
      vec[6]  = '{0,1,32'hA5A5A5A5, 0,ID,32'h10,0,32'h0,        0,ID,32'h0,32'h0,     0,ID,32'h10,32'h0,        1,0,32'h0};
      vec[7]  = '{0,1,32'h0,        1,NS,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 0,NS,32'h100,32'h1111,   1,0,32'h0};
      vec[8]  = '{0,1,32'h0,        1,NS,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 1,NS,32'h200,32'h1111,   1,1,32'h0};
      vec[9]  = '{0,1,32'h0,        1,NS,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 0,NS,32'h100,32'h2222,   1,1,32'h0};
      vec[10] = '{0,1,32'h0,        1,NS,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 1,NS,32'h200,32'h1111,   1,1,32'h0};
      vec[11] = '{0,0,32'h0,        1,NS,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 0,NS,32'h100,32'h2222,   0,0,32'h0};
      vec[12] = '{0,0,32'h0,        1,NS,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 0,NS,32'h100,32'h2222,   0,0,32'h0};
      vec[13] = '{0,1,32'h0,        1,NS,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 0,NS,32'h100,32'h2222,   1,1,32'h0};
      vec[14] = '{0,1,32'h0,        0,ID,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 1,NS,32'h200,32'h1111,   1,1,32'h0};
      vec[15] = '{0,1,32'h0,        0,ID,32'h100,1,32'h1111,    1,NS,32'h200,32'h2222, 1,NS,32'h200,32'h2222,   0,1,32'h0};
      vec[16] = '{0,1,32'h0,        0,ID,32'h100,1,32'h1111,    0,ID,32'h200,32'h2222, 1,ID,32'h200,32'h2222,   0,1,32'h0};
      vec[17] = '{0,1,32'h0,        0,ID,32'h100,1,32'h1111,    0,ID,32'h200,32'h2222, 1,ID,32'h200,32'h2222,   0,1,32'h0};

      advance();
      advance();

      for (int i = 0; i < 18; i++) begin
         HRESET = vec[i].rst; b_srdy = vec[i].s_rdy; b_srd = vec[i].s_rd;
         setm(0, vec[i].sel0, vec[i].tr0, vec[i].addr0, HBURST_SINGLE, vec[i].wr0, vec[i].wd0);
         setm(1, vec[i].sel1, vec[i].tr1, vec[i].addr1, HBURST_SINGLE, 1'b1, vec[i].wd1);
         settle();
         chk($sformatf("v%0d_grant", i),  {31'b0, GRANT}, {31'b0, vec[i].e_grant});
         chk($sformatf("v%0d_locked", i), {31'b0, LOCKED}, 32'h0);
         chk($sformatf("v%0d_htrans", i), {30'b0, s_if.htrans}, {30'b0, vec[i].e_htrans});
         chk($sformatf("v%0d_haddr", i),  s_if.haddr, vec[i].e_haddr);
         chk($sformatf("v%0d_hwdata", i), s_if.hwdata, vec[i].e_hwdata);
         chk($sformatf("v%0d_m0_rdy", i), {31'b0, m0_if.hready}, {31'b0, vec[i].e_rdy0});
         chk($sformatf("v%0d_m1_rdy", i), {31'b0, m1_if.hready}, {31'b0, vec[i].e_rdy1});
         chk($sformatf("v%0d_m0_rd", i),  m0_if.hrdata, vec[i].e_rd0);
         advance();
      end

      // M0 WRAP4 read while M1 waits; M1 gets the bus right after beat 4.
      HRESET = 1'b1; b_srdy = 1'b1; b_srd = 32'h0;
      setm(0, 0, ID, 32'h0, HBURST_SINGLE, 0, 32'h0);
      setm(1, 0, ID, 32'h0, HBURST_SINGLE, 1, 32'h0);
      advance();
      HRESET = 1'b0;
      setm(0, 1, NS, 32'h20, HBURST_WRAP4, 0, 32'h0);
      setm(1, 1, NS, 32'h300, HBURST_SINGLE, 1, 32'h3333);
      settle();
      chk("w4_b1_grant", {31'b0, GRANT}, 32'h0);
      chk("w4_b1_locked", {31'b0, LOCKED}, 32'h0);
      advance();
      for (int b = 1; b < 4; b++) begin
         setm(0, 1, SQ, 32'h20 + 32'(4 * b), HBURST_WRAP4, 0, 32'h0);
         settle();
         chk("w4_grant", {31'b0, GRANT}, 32'h0);
         chk("w4_locked", {31'b0, LOCKED}, 32'h1);
         chk("w4_haddr", s_if.haddr, 32'h20 + 32'(4 * b));
         chk("w4_m1_rdy", {31'b0, m1_if.hready}, 32'h0);
         advance();
      end
      setm(0, 0, ID, 32'h2C, HBURST_WRAP4, 0, 32'h0);
      settle();
      chk("w4_after_grant", {31'b0, GRANT}, 32'h1);
      chk("w4_after_locked", {31'b0, LOCKED}, 32'h0);
      chk("w4_after_htrans", {30'b0, s_if.htrans}, {30'b0, NS});
      chk("w4_after_haddr", s_if.haddr, 32'h300);
      advance();

      // Seven wait states during M1's data phase while M0 is requesting.
      setm(1, 0, ID, 32'h300, HBURST_SINGLE, 1, 32'h3333);
      setm(0, 1, NS, 32'h400, HBURST_SINGLE, 1, 32'h4444);
      b_srdy = 1'b0; b_srd = 32'hDEAD0001;
      for (int c = 0; c < 7; c++) begin
         settle();
         chk("stall_grant", {31'b0, GRANT}, 32'h1);
         chk("stall_htrans", {30'b0, s_if.htrans}, {30'b0, ID});
         chk("stall_haddr", s_if.haddr, 32'h300);
         chk("stall_hwdata", s_if.hwdata, 32'h3333);
         chk("stall_m1_rdy", {31'b0, m1_if.hready}, 32'h0);
         chk("stall_m1_rd", m1_if.hrdata, 32'hDEAD0001);
         advance();
      end
      b_srdy = 1'b1;
      settle();
      chk("stall_end_m1_rdy", {31'b0, m1_if.hready}, 32'h1);
      chk("stall_end_grant", {31'b0, GRANT}, 32'h1);
      advance();
      settle();
      chk("m0_won_grant", {31'b0, GRANT}, 32'h0);
      chk("m0_won_haddr", s_if.haddr, 32'h400);
      chk("m0_won_m1_rdy", {31'b0, m1_if.hready}, 32'h0);
      advance();

      // Reset on the second beat of an M1 WRAP4.
      setm(0, 0, ID, 32'h400, HBURST_SINGLE, 1, 32'h4444);
      setm(1, 1, NS, 32'h500, HBURST_WRAP4, 0, 32'h0);
      settle();
      advance();
      settle();
      chk("rb_b1_grant", {31'b0, GRANT}, 32'h1);
      advance();
      setm(1, 1, SQ, 32'h504, HBURST_WRAP4, 0, 32'h0);
      HRESET = 1'b1;
      settle();
      chk("rb_b2_locked", {31'b0, LOCKED}, 32'h1);
      advance();
      HRESET = 1'b0;
      setm(1, 0, ID, 32'h508, HBURST_WRAP4, 0, 32'h0);
      settle();
      chk("rb_grant", {31'b0, GRANT}, 32'h0);
      chk("rb_locked", {31'b0, LOCKED}, 32'h0);
      chk("rb_m1_rdy", {31'b0, m1_if.hready}, 32'h0);
      advance();

      // M0 abandons a WRAP4 after beat 1; M1 takes over on that edge.
      setm(0, 1, NS, 32'h600, HBURST_WRAP4, 0, 32'h0);
      setm(1, 1, NS, 32'h700, HBURST_SINGLE, 1, 32'h7777);
      settle();
      chk("ab_b1_grant", {31'b0, GRANT}, 32'h0);
      advance();
      setm(0, 1, ID, 32'h604, HBURST_WRAP4, 0, 32'h0);
      settle();
      chk("ab_idle_locked", {31'b0, LOCKED}, 32'h1);
      chk("ab_idle_grant", {31'b0, GRANT}, 32'h0);
      advance();
      settle();
      chk("ab_locked", {31'b0, LOCKED}, 32'h0);
      chk("ab_grant", {31'b0, GRANT}, 32'h1);
      chk("ab_haddr", s_if.haddr, 32'h700);
      advance();

      // Randomized traffic against the model.
      for (int c = 0; c < 800; c++) begin
         HRESET  = ($urandom_range(0, 99) == 0);
         b_srdy  = ($urandom_range(0, 3) != 0);
         b_srd   = $urandom;
         b_sresp = ($urandom_range(0, 7) == 0);
         for (int n = 0; n < 2; n++) begin
            r = $urandom_range(0, 5);
            b_sel[n]   = ($urandom_range(0, 7) != 0);
            b_tr[n]    = (r == 0) ? ID : (r == 1) ? NS : (r == 5) ? 2'b01 : SQ;
            b_burst[n] = $urandom_range(0, 1) ? HBURST_WRAP4 : HBURST_SINGLE;
            b_size[n]  = 3'($urandom_range(0, 7));
            b_wr[n]    = 1'($urandom_range(0, 1));
            b_addr[n]  = $urandom;
            b_wd[n]    = $urandom;
         end
         settle();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
